regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32: data width in bits.
REQ-002 Parameter DEPTH, default 32: register count; power of two, >= 4; entry 0 is hardwired zero.
REQ-003 Parameter NRD, default 2: number of read ports; AW = log2(DEPTH).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 en  input  1  write/issue enable; low freezes architectural updates (pipeline stall).
REQ-007 clr_req  input  1  request full register clear.
REQ-008 ready  output  1  high when the clear sequencer is IDLE.
REQ-009 rs_addr  input  NRD*AW  packed read addresses; port i at bits [i*AW +: AW].
REQ-010 rs_data  output  NRD*XLEN  packed read data, same packing.
REQ-011 rs_busy  output  NRD  per-port pending (scoreboard) flag.
REQ-012 we / rd / wdata  input  1 / AW / XLEN  writeback valid, index, data.
REQ-013 iss_valid / iss_rd  input  1 / AW  issue of an instruction that will write iss_rd.

Function
REQ-014 Reads are combinational; rs_addr=0 returns data 0 and busy 0 on every port.
REQ-015 Write commits at the rising edge when ready && en && we && rd!=0; writes to index 0 are discarded.
REQ-016 Write-through bypass: when a write qualifies per REQ-015 and rd equals a port's nonzero address, that port returns wdata in the same cycle.
REQ-017 Pending bit pend[k] sets at the edge when ready && en && iss_valid && iss_rd==k && k!=0.
REQ-018 pend[k] clears at the edge when a write to k qualifies per REQ-015.
REQ-019 Same edge set and clear of the same index: set wins (the newer producer owns the register).
REQ-020 rs_busy[i] = pend[addr_i] && !(qualifying write to addr_i this cycle).
REQ-021 Clear sequencer states: CLEAR, IDLE; internal pointer ptr of width AW.
REQ-022 In CLEAR, one entry per edge: entry ptr is written 0, ptr increments; en is ignored and clearing proceeds during stalls.
REQ-023 CLEAR -> IDLE on the edge that clears entry DEPTH-1; ready is high from that edge onward.
REQ-024 IDLE -> CLEAR on an edge with clr_req=1; the same edge zeroes all pend bits and loads ptr=1.
REQ-025 clr_req while in CLEAR is ignored; clearing is not restarted.
REQ-026 While ready=0: rs_data=0 and rs_busy=0 on all ports; we and iss_valid are ignored.
REQ-027 Full clear latency: DEPTH-1 edges from entry to ready=1 (31 at default).

Reset
REQ-028 rst_n low asynchronously forces state=CLEAR, ptr=1 and all pend=0; ready=0, rs_busy=0 and rs_data=0 immediately.
REQ-029 Storage is not reset directly; it is zeroed only by the sequencer after rst_n rises. The first edge with rst_n high clears entry 1.
REQ-030 Reset asserted mid-operation (IDLE or CLEAR) aborts it and restarts the full clear from ptr=1 after release.

Structure
REQ-031 Shared package rf_pkg holds the state encoding (CLEAR, IDLE) and the AW derivation function.
REQ-032 Clear sequencer (state, ptr, ready) is sub-module rf_clear_fsm; storage, bypass and scoreboard stay in regfile_sb.

Verification
REQ-033 Release reset, hold clr_req=0 -> ready rises after exactly 31 edges; every read returns 0 throughout.
REQ-034 After ready: write x5=0xDEADBEEF with port0 addr=5 in the same cycle -> port0 reads 0xDEADBEEF that cycle (bypass) and on the next cycle.
REQ-035 Issue rd=7, then en=0 for 3 cycles with we=1 rd=7 -> busy stays 1 and x7 is unchanged; en=1 -> busy=0 and x7 is updated.
REQ-036 Same edge iss_rd=9 and write rd=9 -> x9 is written and pend[9]=1 afterwards.
REQ-037 Write x0=0x1 and issue rd=0 -> reads of x0 return 0 with busy 0.
REQ-038 clr_req with x3=0x55 and pend[3]=1, then rst_n pulsed at clear step 10 -> ready=0 immediately, full 31-edge clear after release, x3=0 at ready.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file: clear-sequencer
// state encoding and the address-width derivation.
package rf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rf_clear_fsm.sv
// Clear sequencer: walks entries 1..DEPTH-1 once per edge after reset or
// on request, then holds ready high until the next clear.
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          ready,
  output logic [AW-1:0] ptr
);

  clr_state_t state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= AW'(1);
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          ptr <= ptr + AW'(1);
          if (ptr == AW'(DEPTH - 1)) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            ptr   <= AW'(1);
            ready <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
          ptr   <= AW'(1);
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass, a per-entry pending
// scoreboard and a sequenced clear; entry 0 always reads as zero.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2,
  localparam int AW   = addr_width(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr_req,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                we,
  input  logic [AW-1:0]       rd,
  input  logic [XLEN-1:0]     wdata,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd
);

  logic [XLEN-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [AW-1:0]   ptr;
  logic            wr_q;
  logic            iss_q;

  rf_clear_fsm #(.DEPTH(DEPTH), .AW(AW)) u_clear (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_req(clr_req),
    .ready  (ready),
    .ptr    (ptr)
  );

  assign wr_q  = ready && en && we && (rd != '0);
  assign iss_q = ready && en && iss_valid && (iss_rd != '0);

  // NOTE: storage has no reset; the clear sequencer zeroes it entry by entry
  // after reset, and reads are masked to zero until it finishes.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[ptr] <= '0;
    end else if (wr_q) begin
      mem[rd] <= wdata;
    end
  end

  // A clear request wipes the scoreboard; otherwise a new issue beats a
  // same-edge writeback so the newer producer keeps ownership.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else if (ready && clr_req) begin
      pend <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        if (iss_q && iss_rd == AW'(k)) begin
          pend[k] <= 1'b1;
        end else if (wr_q && rd == AW'(k)) begin
          pend[k] <= 1'b0;
        end
      end
      pend[0] <= 1'b0;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (ready && rs_addr[i*AW +: AW] != '0) begin
        if (wr_q && rd == rs_addr[i*AW +: AW]) begin
          rs_data[i*XLEN +: XLEN] = wdata;
        end else begin
          rs_data[i*XLEN +: XLEN] = mem[rs_addr[i*AW +: AW]];
          rs_busy[i]              = pend[rs_addr[i*AW +: AW]];
        end
      end
    end
  end

endmodule
